// File: rtl/mem_access_stage_pkg.sv
// Shared CPU definitions for the memory-access stage: opcodes, FSM states,
// memtoreg encodings and opcode classification helpers.
package mem_access_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,
        MTR_MEM  = 2'b01,
        MTR_LINK = 2'b10
    } memtoreg_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_LH) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Word ops need addr[1:0]==0, halfword ops need addr[0]==0; bytes never fault.
    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        if ((op == OP_LW) || (op == OP_SW))
            r = (addr_lo != 2'b00);
        else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
            r = addr_lo[0];
        return r;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the M stage (master) and memory (slave).
interface mem_access_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store byte enables/lane placement and
// load byte/halfword extraction with sign or zero extension (little-endian lanes).
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_ld_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_st_data,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_ld_word[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_ld_word[7:0];
            2'd1: w_byte = i_ld_word[15:8];
            2'd2: w_byte = i_ld_word[23:16];
            2'd3: w_byte = i_ld_word[31:24];
            default: w_byte = i_ld_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    end

    always_comb begin
        o_be      = 4'b0000;
        o_st_data = 32'h0;
        o_ld_data = 32'h0;
        case (i_opcode)
            OP_SW: begin
                o_be      = 4'b1111;
                o_st_data = i_st_data;
            end
            OP_SH: begin
                o_be      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_data = i_addr_lo[1] ? {i_st_data[15:0], 16'h0}
                                         : {16'h0, i_st_data[15:0]};
            end
            OP_SB: begin
                o_be      = 4'b0001 << i_addr_lo;
                o_st_data = {24'h0, i_st_data[7:0]} << {i_addr_lo, 3'b000};
            end
            OP_LW:  o_ld_data = i_ld_word;
            OP_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU: o_ld_data = {24'h0, w_byte};
            OP_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
            OP_LHU: o_ld_data = {16'h0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// M stage of the pipeline: issues data-memory accesses, stalls until ack or timeout,
// and loads the M->W register. Optional MEM_ALIGN_CHECK_EN adds misalignment traps (w_exc).
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_regwrite,
    input  logic        m_memwrite,
    input  logic [5:0]  m_opcode,
    input  logic [4:0]  m_wreg,
    input  logic [1:0]  m_memtoreg,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_aluout,
    input  logic [31:0] m_wdata,
    output logic        m_stall,
    mem_access_stage_if.master mem,
    output logic        w_valid,
    output logic        w_regwrite,
    output logic [4:0]  w_wreg,
    output logic [1:0]  w_memtoreg,
    output logic [31:0] w_pc,
    output logic [31:0] w_aluout,
    output logic [31:0] w_rdata,
    output logic        dm_timeout
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        w_exc
`endif
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    mem_state_e  r_state;
    mem_state_e  w_state_nxt;
    logic [CW-1:0] r_cnt;

    logic [5:0]  r_opcode;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic [4:0]  r_wreg;
    logic [1:0]  r_memtoreg;
    logic        r_regwrite;
    logic        r_memwrite;

    logic        w_mis;
    logic        w_accept;
    logic        w_in_wait;
    logic        w_ack;
    logic        w_timeout;
    logic        w_req;
    logic [5:0]  w_op;
    logic [31:0] w_addr;
    logic [31:0] w_sdata;
    logic        w_memwrite;
    logic [3:0]  w_be;
    logic [31:0] w_st_lane;
    logic [31:0] w_ld_data;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_mis = misaligned(m_opcode, m_aluout[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    assign w_accept  = (r_state == S_IDLE) && m_valid && is_mem(m_opcode) && !w_mis;
    assign w_in_wait = (r_state == S_WAIT);
    assign w_ack     = w_in_wait && mem.dm_ack;
    // Ack takes priority over a timeout landing in the same cycle.
    assign w_timeout = w_in_wait && !mem.dm_ack && (r_cnt == CW'(WAIT_MAX - 1));

    // While waiting, the bus is driven from the copies latched at acceptance.
    assign w_op       = w_in_wait ? r_opcode   : m_opcode;
    assign w_addr     = w_in_wait ? r_addr     : m_aluout;
    assign w_sdata    = w_in_wait ? r_wdata    : m_wdata;
    assign w_memwrite = w_in_wait ? r_memwrite : m_memwrite;

    mem_lane_align u_lane (
        .i_opcode  (w_op),
        .i_addr_lo (w_addr[1:0]),
        .i_st_data (w_sdata),
        .i_ld_word (mem.dm_rdata),
        .o_be      (w_be),
        .o_st_data (w_st_lane),
        .o_ld_data (w_ld_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        m_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_req       = 1'b1;
                    m_stall     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (w_ack || w_timeout)
                    w_state_nxt = S_IDLE;
                else
                    m_stall = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Reset kills the request and stall immediately, without waiting for a clock.
        if (reset) begin
            w_req   = 1'b0;
            m_stall = 1'b0;
        end
    end

    assign mem.dm_req   = w_req;
    assign mem.dm_we    = w_req && is_store(w_op) && w_memwrite;
    assign mem.dm_addr  = {w_addr[31:2], 2'b00};
    assign mem.dm_be    = w_be;
    assign mem.dm_wdata = w_st_lane;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_opcode   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_pc       <= '0;
            r_wreg     <= '0;
            r_memtoreg <= '0;
            r_regwrite <= 1'b0;
            r_memwrite <= 1'b0;
            dm_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt      <= '0;
                r_opcode   <= m_opcode;
                r_addr     <= m_aluout;
                r_wdata    <= m_wdata;
                r_pc       <= m_pc;
                r_wreg     <= m_wreg;
                r_memtoreg <= m_memtoreg;
                r_regwrite <= m_regwrite;
                r_memwrite <= m_memwrite;
            end else if (w_in_wait) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_timeout)
                dm_timeout <= 1'b1;
        end
    end

    // M->W register; the accept edge inserts a bubble so W never re-commits an old instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_valid    <= 1'b0;
            w_regwrite <= 1'b0;
            w_wreg     <= '0;
            w_memtoreg <= '0;
            w_pc       <= '0;
            w_aluout   <= '0;
            w_rdata    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            w_exc      <= 1'b0;
`endif
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                w_valid    <= 1'b0;
                w_regwrite <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                w_exc      <= 1'b0;
`endif
            end else begin
                w_valid    <= m_valid;
                w_regwrite <= m_valid && m_regwrite && !w_mis;
                w_wreg     <= m_wreg;
                w_memtoreg <= m_memtoreg;
                w_pc       <= m_pc;
                w_aluout   <= m_aluout;
                w_rdata    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                w_exc      <= m_valid && w_mis;
`endif
            end
        end else if (w_ack || w_timeout) begin
            w_valid    <= 1'b1;
            w_regwrite <= r_regwrite && !w_timeout;
            w_wreg     <= r_wreg;
            w_memtoreg <= r_memtoreg;
            w_pc       <= r_pc;
            w_aluout   <= r_addr;
            w_rdata    <= w_timeout ? 32'h0 : w_ld_data;
`ifdef MEM_ALIGN_CHECK_EN
            w_exc      <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (optionally with MEM_ALIGN_CHECK_EN).
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        m_valid, m_regwrite, m_memwrite;
    logic [5:0]  m_opcode;
    logic [4:0]  m_wreg;
    logic [1:0]  m_memtoreg;
    logic [31:0] m_pc, m_aluout, m_wdata;
    logic        m_stall;
    logic        w_valid, w_regwrite;
    logic [4:0]  w_wreg;
    logic [1:0]  w_memtoreg;
    logic [31:0] w_pc, w_aluout, w_rdata;
    logic        dm_timeout;
`ifdef MEM_ALIGN_CHECK_EN
    logic        w_exc;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_stall  = 0;

    mem_access_stage_if dmif ();

    mem_access_stage #(.WAIT_MAX(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_regwrite (m_regwrite),
        .m_memwrite (m_memwrite),
        .m_opcode   (m_opcode),
        .m_wreg     (m_wreg),
        .m_memtoreg (m_memtoreg),
        .m_pc       (m_pc),
        .m_aluout   (m_aluout),
        .m_wdata    (m_wdata),
        .m_stall    (m_stall),
        .mem        (dmif),
        .w_valid    (w_valid),
        .w_regwrite (w_regwrite),
        .w_wreg     (w_wreg),
        .w_memtoreg (w_memtoreg),
        .w_pc       (w_pc),
        .w_aluout   (w_aluout),
        .w_rdata    (w_rdata),
        .dm_timeout (dm_timeout)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .w_exc      (w_exc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic v, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic rw, input logic mw,
                         input logic [4:0] wr, input logic [31:0] pc);
        m_valid    = v;
        m_opcode   = op;
        m_aluout   = addr;
        m_wdata    = wd;
        m_regwrite = rw;
        m_memwrite = mw;
        m_wreg     = wr;
        m_pc       = pc;
        m_memtoreg = 2'd1;
    endtask

    // Called in the accept cycle; inputs are scrambled in WAIT to prove the latched copies are used.
    task automatic complete(input logic [31:0] rdata, input int n_wait);
        tick();
        m_aluout = 32'hFFFF_FFFC;
        m_wdata  = 32'h5A5A_5A5A;
        m_opcode = 6'h00;
        m_wreg   = 5'd0;
        for (int i = 0; i < n_wait; i++) begin
            chk("wait_stall", m_stall, 1);
            tick();
        end
        dmif.dm_ack   = 1'b1;
        dmif.dm_rdata = rdata;
        #1;
        chk("ack_stall_low", m_stall, 0);
        tick();
        dmif.dm_ack   = 1'b0;
        dmif.dm_rdata = 32'h0;
        m_valid       = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_m(0, 6'h00, 0, 0, 0, 0, 0, 0);
        dmif.dm_ack   = 1'b0;
        dmif.dm_rdata = 32'h0;
        #1;
        chk("rst_req", dmif.dm_req, 0);
        chk("rst_stall", m_stall, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_w_regwrite", w_regwrite, 0);
        chk("rst_w_rdata", w_rdata, 0);
        chk("rst_timeout", dm_timeout, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // lw 0x10, ack two cycles after the request
        set_m(1, 6'h23, 32'h10, 32'h0, 1, 0, 5'd5, 32'h100);
        #1;
        chk("lw_req", dmif.dm_req, 1);
        chk("lw_stall0", m_stall, 1);
        chk("lw_addr", dmif.dm_addr, 32'h10);
        chk("lw_we", dmif.dm_we, 0);
        tick();
        m_aluout = 32'hFFFF_FFF0;
        #1;
        chk("lw_wait_req", dmif.dm_req, 1);
        chk("lw_stall1", m_stall, 1);
        chk("lw_addr_held", dmif.dm_addr, 32'h10);
        tick();
        dmif.dm_ack   = 1'b1;
        dmif.dm_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw_ack_stall", m_stall, 0);
        tick();
        dmif.dm_ack = 1'b0;
        m_valid     = 1'b0;
        #1;
        chk("lw_rdata", w_rdata, 32'hDEAD_BEEF);
        chk("lw_regwrite", w_regwrite, 1);
        chk("lw_w_valid", w_valid, 1);
        chk("lw_wreg", w_wreg, 5'd5);
        chk("lw_pc", w_pc, 32'h100);
        chk("lw_aluout", w_aluout, 32'h10);
        chk("lw_memtoreg", w_memtoreg, 2'd1);
        chk("lw_idle_req", dmif.dm_req, 0);

        // ack while idle is ignored
        dmif.dm_ack = 1'b1;
        #1;
        chk("idle_ack_req", dmif.dm_req, 0);
        tick();
        dmif.dm_ack = 1'b0;
        #1;
        chk("idle_ack_stall", m_stall, 0);
        chk("idle_ack_w_valid", w_valid, 0);

        // sub-word loads
        set_m(1, 6'h20, 32'h13, 0, 1, 0, 5'd6, 32'h104);
        #1;
        complete(32'h8011_2233, 0);
        chk("lb_rdata", w_rdata, 32'hFFFF_FF80);
        set_m(1, 6'h24, 32'h13, 0, 1, 0, 5'd6, 32'h108);
        #1;
        complete(32'h8011_2233, 0);
        chk("lbu_rdata", w_rdata, 32'h0000_0080);
        set_m(1, 6'h21, 32'h12, 0, 1, 0, 5'd7, 32'h10C);
        #1;
        complete(32'h8011_2233, 0);
        chk("lh_rdata", w_rdata, 32'hFFFF_8011);
        set_m(1, 6'h25, 32'h10, 0, 1, 0, 5'd7, 32'h110);
        #1;
        complete(32'h8011_2233, 1);
        chk("lhu_rdata", w_rdata, 32'h0000_2233);

        // stores
        set_m(1, 6'h28, 32'h6, 32'h0000_00AB, 0, 1, 5'd0, 32'h114);
        #1;
        chk("sb_be", dmif.dm_be, 4'b0100);
        chk("sb_lane", dmif.dm_wdata[23:16], 8'hAB);
        chk("sb_we", dmif.dm_we, 1);
        chk("sb_addr", dmif.dm_addr, 32'h4);
        tick();
        m_wdata = 32'h0;
        m_aluout = 32'h0;
        #1;
        chk("sb_be_held", dmif.dm_be, 4'b0100);
        chk("sb_lane_held", dmif.dm_wdata[23:16], 8'hAB);
        dmif.dm_ack   = 1'b1;
        dmif.dm_rdata = 32'hFFFF_FFFF;
        tick();
        dmif.dm_ack = 1'b0;
        m_valid     = 1'b0;
        #1;
        chk("sb_w_rdata", w_rdata, 32'h0);
        chk("sb_w_regwrite", w_regwrite, 0);

        set_m(1, 6'h29, 32'h2, 32'h0000_1234, 0, 1, 5'd0, 32'h118);
        #1;
        chk("sh_be", dmif.dm_be, 4'b1100);
        chk("sh_lane", dmif.dm_wdata[31:16], 16'h1234);
        complete(32'h0, 0);
        set_m(1, 6'h2B, 32'h20, 32'hCAFE_F00D, 0, 1, 5'd0, 32'h11C);
        #1;
        chk("sw_be", dmif.dm_be, 4'b1111);
        chk("sw_wdata", dmif.dm_wdata, 32'hCAFE_F00D);
        complete(32'h0, 0);

        // non-memory op: single-cycle, no request
        set_m(1, 6'h00, 32'h55, 0, 1, 0, 5'd3, 32'h200);
        #1;
        chk("addu_req", dmif.dm_req, 0);
        chk("addu_stall", m_stall, 0);
        tick();
        m_valid = 1'b0;
        #1;
        chk("addu_w_valid", w_valid, 1);
        chk("addu_regwrite", w_regwrite, 1);
        chk("addu_aluout", w_aluout, 32'h55);
        chk("addu_wreg", w_wreg, 5'd3);
        chk("addu_rdata", w_rdata, 32'h0);

        // ack in the same cycle the timeout would fire
        set_m(1, 6'h23, 32'h30, 0, 1, 0, 5'd8, 32'h204);
        #1;
        complete(32'h0BAD_F00D, 15);
        chk("late_ack_rdata", w_rdata, 32'h0BAD_F00D);
        chk("late_ack_regwrite", w_regwrite, 1);
        chk("late_ack_timeout", dm_timeout, 0);

        // no ack at all -> timeout after 16 WAIT cycles
        set_m(1, 6'h23, 32'h40, 0, 1, 0, 5'd9, 32'h208);
        #1;
        n_stall = (m_stall && dmif.dm_req) ? 1 : 0;
        tick();
        for (int i = 0; i < 15; i++) begin
            if (m_stall && dmif.dm_req) n_stall++;
            tick();
        end
        chk("to_stall_cycles", n_stall, 16);
        chk("to_last_stall", m_stall, 0);
        chk("to_not_yet", dm_timeout, 0);
        m_valid = 1'b0;
        tick();
        chk("to_timeout", dm_timeout, 1);
        chk("to_req", dmif.dm_req, 0);
        chk("to_regwrite", w_regwrite, 0);
        chk("to_w_valid", w_valid, 1);
        set_m(1, 6'h00, 32'h1, 0, 1, 0, 5'd1, 32'h20C);
        repeat (3) tick();
        chk("to_sticky", dm_timeout, 1);

        // reset in the middle of a WAIT
        set_m(1, 6'h23, 32'h8, 0, 1, 0, 5'd10, 32'h300);
        tick();
        chk("rw_wait_req", dmif.dm_req, 1);
        reset = 1'b1;
        #1;
        chk("rw_req_async", dmif.dm_req, 0);
        chk("rw_stall_async", m_stall, 0);
        chk("rw_timeout_clr", dm_timeout, 0);
        chk("rw_w_valid_clr", w_valid, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rw_reaccept", dmif.dm_req, 1);
        complete(32'h1234_5678, 0);
        chk("rw_rdata", w_rdata, 32'h1234_5678);
        chk("rw_regwrite", w_regwrite, 1);

`ifdef MEM_ALIGN_CHECK_EN
        chk("al_ok_exc", w_exc, 0);
        set_m(1, 6'h23, 32'h2, 0, 1, 0, 5'd11, 32'h304);
        #1;
        chk("al_req", dmif.dm_req, 0);
        chk("al_stall", m_stall, 0);
        tick();
        m_valid = 1'b0;
        #1;
        chk("al_exc", w_exc, 1);
        chk("al_regwrite", w_regwrite, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have one parameter: WAIT_MAX, default 16, the number of cycles to wait for dm_ack before declaring a timeout.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 m_valid, m_regwrite, m_memwrite  in  1 each  M-stage valid flag and control bits from the E->M register.
REQ-005 m_opcode  in  6; m_wreg  in  5; m_memtoreg  in  2  M-stage instruction fields.
REQ-006 m_pc, m_aluout, m_wdata  in  32 each  M-stage PC, address/ALU result, and store data.
REQ-007 m_stall  out  1  freezes the PC, F, D, E and M stages while high.
REQ-008 dm_req, dm_we  out  1; dm_addr  out  32 (word-aligned); dm_be  out  4; dm_wdata  out  32  data-memory request port.
REQ-009 dm_ack  in  1; dm_rdata  in  32  data-memory response port.
REQ-010 w_valid, w_regwrite  out  1; w_wreg  out  5; w_memtoreg  out  2; w_pc, w_aluout, w_rdata  out  32  M->W register outputs.
REQ-011 dm_timeout  out  1  sticky error flag.

Function
REQ-012 The memory opcodes SHALL be: loads lw 0x23, lb 0x20, lbu 0x24, lh 0x21, lhu 0x25; stores sw 0x2B, sb 0x28, sh 0x29; every other opcode is a non-memory operation.
REQ-013 The FSM SHALL have two states, IDLE and WAIT.
REQ-014 In IDLE with m_valid high and a memory opcode, the block SHALL assert dm_req combinationally, assert m_stall, and move to WAIT.
REQ-015 In IDLE with a non-memory op or m_valid low, the block SHALL load the W register at the next edge (latency 1) with m_stall low.
REQ-016 In WAIT, dm_req and the request fields SHALL come from latched copies taken at acceptance, held constant until the ack.
REQ-017 In WAIT with dm_ack high, the block SHALL drop m_stall in that same cycle, load the W register at that edge, and return to IDLE.
REQ-018 dm_addr SHALL equal {m_aluout[31:2], 2'b00}.
REQ-019 dm_we SHALL be high only for stores.
REQ-020 dm_be SHALL be 1111 for sw, 0011 or 1100 for sh (selected by addr[1]), and a one-hot byte lane for sb (selected by addr[1:0]).
REQ-021 dm_wdata SHALL place the low byte or halfword of m_wdata into the selected lane.
REQ-022 w_rdata SHALL extract the addressed byte or halfword from dm_rdata, sign-extended for lb/lh and zero-extended for lbu/lhu; lw passes the word through; for stores and non-memory ops w_rdata = 0.
REQ-023 A wait counter SHALL count cycles spent in WAIT.
REQ-024 When the counter reaches WAIT_MAX without an ack, the block SHALL drop dm_req, set dm_timeout (sticky until reset), load the W register with w_regwrite forced to 0, and return to IDLE.
REQ-025 A dm_ack arriving in IDLE SHALL be ignored.
REQ-026 When ack and timeout occur in the same cycle, the ack SHALL win.

Reset
REQ-027 reset SHALL force IDLE, clear the wait counter, clear all W outputs and dm_timeout to 0, and drive dm_req and m_stall to 0 immediately (asynchronously), including mid-WAIT.
REQ-028 Any in-flight access SHALL be abandoned on reset.

Configuration
REQ-029 With MEM_ALIGN_CHECK_EN defined, the block SHALL add a port w_exc  out  1.
REQ-030 With MEM_ALIGN_CHECK_EN defined, a misaligned lw/sw (addr[1:0] != 0) or lh/lhu/sh (addr[0] != 0) SHALL issue no dm_req, take latency 1, and set w_exc = 1 with w_regwrite = 0.
REQ-031 Without MEM_ALIGN_CHECK_EN, w_exc SHALL be absent and the low address bits SHALL be used as-is for lane selection.

Structure
REQ-032 The opcode constants, the FSM state encoding, and the memtoreg encodings SHALL live in the shared CPU package used by the controller.
REQ-033 Load extraction/extension and store lane/byte-enable generation SHALL be a combinational sub-module named mem_lane_align.

Verification
REQ-034 lw with m_aluout = 0x10, dm_ack two cycles after dm_req, dm_rdata = 0xDEADBEEF -> m_stall high for 2 cycles, then w_rdata = 0xDEADBEEF and w_regwrite = 1.
REQ-035 lb with addr = 0x13, dm_rdata = 0x80112233 -> w_rdata = 0xFFFFFF80; the same access as lbu -> w_rdata = 0x00000080.
REQ-036 sb with addr = 0x6, m_wdata = 0x000000AB -> dm_be = 0100, dm_wdata[23:16] = 0xAB, dm_we = 1; sh with addr = 0x2 -> dm_be = 1100.
REQ-037 addu (non-memory) -> no dm_req, m_stall stays 0, W outputs updated after 1 edge.
REQ-038 dm_ack never asserted -> after 16 WAIT cycles dm_timeout = 1, dm_req = 0, w_regwrite = 0; dm_timeout holds until reset.
REQ-039 reset asserted mid-WAIT -> dm_req and m_stall fall without a clock edge; the next lw completes normally; with MEM_ALIGN_CHECK_EN, lw at 0x2 -> w_exc = 1 and no dm_req.
